// File: rtl/keypoint_window_scheduler.sv
// keypoint_window_scheduler: 3x3 tap read sequencer and window handshake for the DoG extrema detector
module keypoint_window_scheduler #(
  parameter int N = 480,
  parameter int M = 320,
  parameter int ADDR_W = 18,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              frame_ready,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              cap_en,
  output logic [3:0]        cap_idx,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [9:0]        ctr_row,
  output logic [9:0]        ctr_col,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;
  localparam logic [9:0] LAST_ROW = 10'(N - 2);
  localparam logic [9:0] LAST_COL = 10'(M - 2);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(M - 2);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(3);
  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);
  state_t state, state_nxt;
  logic [3:0] tap;
  logic [1:0] q;
  logic [2:0] wcnt;
  logic [ADDR_W-1:0] addr, base, nbase;
  logic [9:0] row, col;
  logic [4:0] pipe [MEM_LAT];
  logic go, kill, hs, eol, last;
  assign go = state == IDLE && start && frame_ready;
  assign kill = abort && state != IDLE;
  assign hs = state == PRESENT && win_ready && !kill;
  assign eol = col == LAST_COL;
  assign last = eol && row == LAST_ROW;
  assign nbase = base + (eol ? WRAP_STEP : ONE);
  assign rd_en = state == FETCH;
  assign rd_addr = addr;
  assign win_valid = state == PRESENT;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign ctr_row = row;
  assign ctr_col = col;
  assign cap_en = pipe[MEM_LAT-1][4];
  assign cap_idx = pipe[MEM_LAT-1][3:0];
  // next-state logic; abort from any active state wins over everything else
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = go ? FETCH : IDLE;
      FETCH:   state_nxt = tap == 4'd8 ? WAIT : FETCH;
      WAIT:    state_nxt = wcnt == WAIT_LAST ? PRESENT : WAIT;
      PRESENT: state_nxt = win_ready ? (last ? DONE : FETCH) : PRESENT;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // centre position, tap counters and incremental address generation
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row <= 10'd1;
      col <= 10'd1;
      tap <= 4'd0;
      q <= 2'd0;
      wcnt <= 3'd0;
      addr <= '0;
      base <= '0;
    end else if (go) begin
      row <= 10'd1;
      col <= 10'd1;
      tap <= 4'd0;
      q <= 2'd0;
      addr <= '0;
      base <= '0;
    end else if (state == FETCH) begin
      tap <= tap == 4'd8 ? 4'd0 : tap + 4'd1;
      q <= q == 2'd2 ? 2'd0 : q + 2'd1;
      if (tap != 4'd8) addr <= addr + (q == 2'd2 ? ROW_STEP : ONE);
      wcnt <= 3'd0;
    end else if (state == WAIT) begin
      wcnt <= wcnt + 3'd1;
    end else if (hs && !last) begin
      row <= eol ? row + 10'd1 : row;
      col <= eol ? 10'd1 : col + 10'd1;
      base <= nbase;
      addr <= nbase;
    end
  // capture strobe pipeline matching the memory read latency
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= 5'd0;
    end else begin
      pipe[0] <= kill ? 5'd0 : {rd_en, rd_en ? tap : 4'd0};
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= kill ? 5'd0 : pipe[i-1];
    end
endmodule
